// File: rtl/gfx_rom_slot_arbiter_if.sv
// Shared GFX ROM bus bundle: two tilemap fetchers, the CPU readback port and the ROM pins.
// Handshake: REQ_x/CPU_REQ are level requests, and REQ_x must hold ADDR_x steady while high.
// A grant is a one-cycle pulse in window cycle 0 (GNT_x, or ROM_CEn falling for the CPU).
// Data returns with exactly one VLD_x or CPU_ACK pulse. There is no back-pressure on the return.
interface gfx_rom_slot_arbiter_if;
    logic        REQ_A;
    logic [18:0] ADDR_A;
    logic        GNT_A;
    logic        VLD_A;
    logic        REQ_B;
    logic [18:0] ADDR_B;
    logic        GNT_B;
    logic        VLD_B;
    logic        CPU_REQ;
    logic [18:0] CPU_ADDR;
    logic [1:0]  CPU_AB;
    logic        CPU_ACK;
    logic [7:0]  CPU_DB;
    logic [18:0] ROM_ADDR;
    logic        ROM_CEn;
    logic        ROM_OEn_LO;
    logic        ROM_OEn_HI;
    logic [31:0] ROM_DATA;
    logic [31:0] RDATA;
    logic        SLOT0;
    logic        BUSY;

    modport slave (
        input  REQ_A, ADDR_A, REQ_B, ADDR_B, CPU_REQ, CPU_ADDR, CPU_AB, ROM_DATA,
        output GNT_A, VLD_A, GNT_B, VLD_B, CPU_ACK, CPU_DB,
        output ROM_ADDR, ROM_CEn, ROM_OEn_LO, ROM_OEn_HI, RDATA, SLOT0, BUSY
    );

    modport master (
        output REQ_A, ADDR_A, REQ_B, ADDR_B, CPU_REQ, CPU_ADDR, CPU_AB, ROM_DATA,
        input  GNT_A, VLD_A, GNT_B, VLD_B, CPU_ACK, CPU_DB,
        input  ROM_ADDR, ROM_CEn, ROM_OEn_LO, ROM_OEn_HI, RDATA, SLOT0, BUSY
    );
endinterface

// File: rtl/gfx_rom_slot_arbiter.sv
// Fixed-window arbiter for the shared tile GFX ROM: one access per SLOT_CYCLES window,
// granted to layer A, layer B or CPU readback, with CPU starvation override.
module gfx_rom_slot_arbiter #(
    parameter int SLOT_CYCLES = 8,
    parameter int ROM_LAT     = 5,
    parameter int STARVE_MAX  = 3
) (
    input  logic                         M24,
    input  logic                         RES,
    gfx_rom_slot_arbiter_if.slave        bus,
    output logic [1:0]                   dbg_owner
);
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] LAST_CYC   = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] DONE_CYC   = CW'(ROM_LAT + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2,
        OWN_CPU  = 2'd3
    } owner_e;

    // slot_cnt_q is the window cycle the next clock edge enters.
    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    owner_e        owner_q, owner_d, win;
    logic [SW-1:0] starve_q, starve_d;
    logic [18:0]   rom_addr_q, rom_addr_d, win_addr;
    logic          cen_q, cen_d, oen_lo_q, oen_lo_d, oen_hi_q, oen_hi_d;
    logic          gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic          vld_a_q, vld_a_d, vld_b_q, vld_b_d, ack_q, ack_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [7:0]    cpu_db_q, cpu_db_d, sel_byte;
    logic [1:0]    cpu_ab_q, cpu_ab_d;
    logic          busy_q, busy_d, slot0_q, slot0_d;

    always_comb begin
        slot_cnt_d = (slot_cnt_q == LAST_CYC) ? '0 : slot_cnt_q + 1'b1;
        slot0_d    = (slot_cnt_q == '0);
        owner_d    = owner_q;
        starve_d   = starve_q;
        rom_addr_d = rom_addr_q;
        cen_d      = cen_q;
        oen_lo_d   = oen_lo_q;
        oen_hi_d   = oen_hi_q;
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        vld_a_d    = 1'b0;
        vld_b_d    = 1'b0;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;
        cpu_db_d   = cpu_db_q;
        cpu_ab_d   = cpu_ab_q;
        busy_d     = busy_q;
        win        = OWN_NONE;
        win_addr   = rom_addr_q;
        sel_byte   = bus.ROM_DATA[7:0];

        case (cpu_ab_q)
            2'd0:    sel_byte = bus.ROM_DATA[7:0];
            2'd1:    sel_byte = bus.ROM_DATA[15:8];
            2'd2:    sel_byte = bus.ROM_DATA[23:16];
            default: sel_byte = bus.ROM_DATA[31:24];
        endcase

        if (slot_cnt_q == '0) begin
            if (bus.CPU_REQ && starve_q == STARVE_TOP) win = OWN_CPU;
            else if (bus.REQ_A)                       win = OWN_A;
            else if (bus.REQ_B)                       win = OWN_B;
            else if (bus.CPU_REQ)                     win = OWN_CPU;

            // Starvation only accrues while the CPU is actually waiting.
            if (!bus.CPU_REQ || win == OWN_CPU)
                starve_d = '0;
            else if (starve_q != STARVE_TOP)
                starve_d = starve_q + 1'b1;

            case (win)
                OWN_A:   win_addr = bus.ADDR_A;
                OWN_B:   win_addr = bus.ADDR_B;
                OWN_CPU: win_addr = bus.CPU_ADDR;
                default: win_addr = rom_addr_q;
            endcase

            owner_d = win;
            if (win != OWN_NONE) begin
                rom_addr_d = win_addr;
                cen_d      = 1'b0;
                oen_lo_d   = win_addr[18];
                oen_hi_d   = ~win_addr[18];
                busy_d     = 1'b1;
                gnt_a_d    = (win == OWN_A);
                gnt_b_d    = (win == OWN_B);
                if (win == OWN_CPU) cpu_ab_d = bus.CPU_AB;
            end
        end else if (slot_cnt_q == DONE_CYC && owner_q != OWN_NONE) begin
            // This edge closes cycle ROM_LAT: capture and release the bus together.
            rdata_d  = bus.ROM_DATA;
            vld_a_d  = (owner_q == OWN_A);
            vld_b_d  = (owner_q == OWN_B);
            ack_d    = (owner_q == OWN_CPU);
            if (owner_q == OWN_CPU) cpu_db_d = sel_byte;
            cen_d    = 1'b1;
            oen_lo_d = 1'b1;
            oen_hi_d = 1'b1;
            busy_d   = 1'b0;
            owner_d  = OWN_NONE;
        end
    end

    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            slot_cnt_q <= '0;
            slot0_q    <= 1'b0;
            owner_q    <= OWN_NONE;
            starve_q   <= '0;
            rom_addr_q <= '0;
            cen_q      <= 1'b1;
            oen_lo_q   <= 1'b1;
            oen_hi_q   <= 1'b1;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            vld_a_q    <= 1'b0;
            vld_b_q    <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            cpu_db_q   <= '0;
            cpu_ab_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            slot0_q    <= slot0_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            rom_addr_q <= rom_addr_d;
            cen_q      <= cen_d;
            oen_lo_q   <= oen_lo_d;
            oen_hi_q   <= oen_hi_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            vld_a_q    <= vld_a_d;
            vld_b_q    <= vld_b_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            cpu_db_q   <= cpu_db_d;
            cpu_ab_q   <= cpu_ab_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.GNT_A      = gnt_a_q;
    assign bus.GNT_B      = gnt_b_q;
    assign bus.VLD_A      = vld_a_q;
    assign bus.VLD_B      = vld_b_q;
    assign bus.CPU_ACK    = ack_q;
    assign bus.CPU_DB     = cpu_db_q;
    assign bus.ROM_ADDR   = rom_addr_q;
    assign bus.ROM_CEn    = cen_q;
    assign bus.ROM_OEn_LO = oen_lo_q;
    assign bus.ROM_OEn_HI = oen_hi_q;
    assign bus.RDATA      = rdata_q;
    assign bus.SLOT0      = slot0_q;
    assign bus.BUSY       = busy_q;
    assign dbg_owner      = owner_q;
endmodule

// File: tb/tb_gfx_rom_slot_arbiter.sv
// Bench for gfx_rom_slot_arbiter: ROM model, requester drivers, and a scoreboard of
// expected {kind, data} returns checked on every VLD/ACK strobe.
module tb_gfx_rom_slot_arbiter;
    localparam int SLOT_CYCLES = 8;
    localparam int ROM_LAT     = 5;
    localparam int STARVE_MAX  = 3;
    localparam int W           = 34;
    localparam logic [1:0] K_A   = 2'd0;
    localparam logic [1:0] K_B   = 2'd1;
    localparam logic [1:0] K_CPU = 2'd2;

    logic        M24 = 1'b0;
    logic        RES;
    logic [1:0]  dbg_owner;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_gnt_cyc = 0;
    logic [W-1:0] exp_q[$];

    gfx_rom_slot_arbiter_if bus();

    gfx_rom_slot_arbiter #(
        .SLOT_CYCLES(SLOT_CYCLES),
        .ROM_LAT(ROM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .M24(M24),
        .RES(RES),
        .bus(bus),
        .dbg_owner(dbg_owner)
    );

    // ---------------- clock / reset ----------------
    always #5 M24 = ~M24;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- ROM model ----------------
    function automatic logic [31:0] rom_word(input logic [18:0] a);
        logic [31:0] w;
        case (a)
            19'h00003: w = 32'hA5A5_0F0F;
            19'h00020: w = 32'h1122_3344;
            default:   w = {a[7:0] ^ 8'hC3, a[15:8], 5'd0, a[18:16], a[7:0] ^ 8'h3C};
        endcase
        return w;
    endfunction

    // Data is driven only when the chip and the matching half are both enabled.
    assign bus.ROM_DATA = (!bus.ROM_CEn && (bus.ROM_ADDR[18] ? !bus.ROM_OEn_HI : !bus.ROM_OEn_LO))
                          ? rom_word(bus.ROM_ADDR) : 32'hDEAD_BEEF;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_entry(input logic [1:0] kind, input logic [18:0] addr,
                                               input logic [1:0] ab);
        logic [31:0] w;
        logic [31:0] sh;
        w  = rom_word(addr);
        sh = w >> (8 * ab);
        return (kind == K_CPU) ? {kind, 24'd0, sh[7:0]} : {kind, w};
    endfunction

    function automatic logic cpu_granted();
        return bus.SLOT0 && !bus.ROM_CEn && !bus.GNT_A && !bus.GNT_B;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge M24) begin
        logic [W-1:0] e;
        logic [1:0]   k;
        logic [18:0]  ea;
        logic [31:0]  d;
        int           nstb;
        cyc++;
        if (RES === 1'b1) begin
            if (bus.SLOT0 && !bus.ROM_CEn) begin
                k  = bus.GNT_A ? K_A : (bus.GNT_B ? K_B : K_CPU);
                ea = (k == K_A) ? bus.ADDR_A : ((k == K_B) ? bus.ADDR_B : bus.CPU_ADDR);
                last_gnt_cyc = cyc;
                check("gnt_onehot", {63'd0, bus.GNT_A & bus.GNT_B}, 64'd0);
                check("gnt_addr", {45'd0, bus.ROM_ADDR}, {45'd0, ea});
                check("gnt_oen", {62'd0, bus.ROM_OEn_LO, bus.ROM_OEn_HI}, {62'd0, ea[18], ~ea[18]});
                check("gnt_busy", {63'd0, bus.BUSY}, 64'd1);
            end else if (bus.GNT_A || bus.GNT_B) begin
                check("gnt_stray", 64'd1, 64'd0);
            end
            nstb = int'(bus.VLD_A) + int'(bus.VLD_B) + int'(bus.CPU_ACK);
            if (nstb > 1) begin
                check("strobe_multi", nstb, 64'd1);
            end else if (nstb == 1) begin
                k = bus.VLD_A ? K_A : (bus.VLD_B ? K_B : K_CPU);
                d = (k == K_CPU) ? {24'd0, bus.CPU_DB} : bus.RDATA;
                if (exp_q.size() == 0) begin
                    check("strobe_unexp", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", {62'd0, k}, {62'd0, e[33:32]});
                    check("strobe_data", {32'd0, d}, {32'd0, e[31:0]});
                    check("strobe_lat", cyc - last_gnt_cyc, ROM_LAT + 1);
                    check("strobe_bus_idle", {62'd0, bus.ROM_CEn, bus.BUSY}, 64'd2);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_drain();
        for (int i = 0; i < 3 * SLOT_CYCLES && exp_q.size() != 0; i++) @(negedge M24);
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic set_req(input logic [1:0] kind, input logic v);
        if (kind == K_A)      bus.REQ_A   = v;
        else if (kind == K_B) bus.REQ_B   = v;
        else                  bus.CPU_REQ = v;
    endtask

    task automatic fetch(input logic [1:0] kind, input logic [18:0] addr, input logic [1:0] ab);
        logic seen;
        int   bad;
        seen = 1'b0;
        bad  = 0;
        exp_q.push_back(exp_entry(kind, addr, ab));
        if (kind == K_A)      bus.ADDR_A   = addr;
        else if (kind == K_B) bus.ADDR_B   = addr;
        else begin
            bus.CPU_ADDR = addr;
            bus.CPU_AB   = ab;
        end
        set_req(kind, 1'b1);
        for (int i = 0; i < 3 * SLOT_CYCLES && !seen; i++) begin
            @(negedge M24);
            if ((kind == K_A && bus.GNT_A) || (kind == K_B && bus.GNT_B) ||
                (kind == K_CPU && cpu_granted())) seen = 1'b1;
        end
        check("gnt_seen", {63'd0, seen}, 64'd1);
        #1;
        set_req(kind, 1'b0);
        // Scramble inputs after grant: the window must keep what it latched.
        bus.ADDR_A   = ~bus.ADDR_A;
        bus.ADDR_B   = ~bus.ADDR_B;
        bus.CPU_ADDR = ~bus.CPU_ADDR;
        bus.CPU_AB   = ~ab;
        if (seen) begin
            for (int c = 1; c <= ROM_LAT; c++) begin
                @(negedge M24);
                if (bus.ROM_CEn !== 1'b0 || bus.BUSY !== 1'b1 || bus.ROM_ADDR !== addr ||
                    bus.ROM_OEn_LO !== addr[18] || bus.ROM_OEn_HI !== ~addr[18]) bad++;
            end
            check("window_hold", bad, 64'd0);
        end
        wait_drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] got_seq;
        logic [15:0] exp_seq;
        int          bad;
        int          bad_slot;
        int          n_gnt;
        logic [1:0]  k;

        RES = 1'b0;
        bus.REQ_A = 1'b0;   bus.ADDR_A = '0;
        bus.REQ_B = 1'b0;   bus.ADDR_B = '0;
        bus.CPU_REQ = 1'b0; bus.CPU_ADDR = '0; bus.CPU_AB = '0;

        // Reset and idle
        repeat (3) @(negedge M24);
        check("rst_ctl", {59'd0, bus.ROM_CEn, bus.ROM_OEn_LO, bus.ROM_OEn_HI, bus.BUSY, bus.SLOT0}, 64'h1C);
        check("rst_strobes", {59'd0, bus.GNT_A, bus.GNT_B, bus.VLD_A, bus.VLD_B, bus.CPU_ACK}, 64'd0);
        check("rst_data", {bus.RDATA, 5'd0, bus.ROM_ADDR, bus.CPU_DB}, 64'd0);
        RES = 1'b1;
        bad = 0;
        bad_slot = 0;
        for (int i = 0; i < 4 * SLOT_CYCLES; i++) begin
            @(negedge M24);
            if (bus.SLOT0 !== ((i % SLOT_CYCLES) == 0)) bad_slot++;
            if (bus.ROM_CEn !== 1'b1 || bus.ROM_OEn_LO !== 1'b1 || bus.ROM_OEn_HI !== 1'b1 ||
                bus.BUSY !== 1'b0 || bus.GNT_A || bus.GNT_B || bus.VLD_A || bus.VLD_B ||
                bus.CPU_ACK) bad++;
        end
        check("idle_slot0", bad_slot, 64'd0);
        check("idle_bus", bad, 64'd0);

        // Directed accesses
        fetch(K_A, 19'h00003, 2'd0);
        check("a_rdata", {32'd0, bus.RDATA}, 64'hA5A5_0F0F);
        fetch(K_B, 19'h4001C, 2'd0);
        fetch(K_CPU, 19'h00020, 2'd2);
        check("cpu_db", {56'd0, bus.CPU_DB}, 64'h22);
        check("cpu_rdata", {32'd0, bus.RDATA}, 64'h1122_3344);
        fetch(K_A, 19'h00005, 2'd0);
        check("cpu_db_hold", {56'd0, bus.CPU_DB}, 64'h22);

        // Random accesses
        for (int i = 0; i < 8; i++) begin
            k = 2'($urandom_range(0, 2));
            fetch(k, 19'($urandom_range(0, 19'h7FFFF)), 2'($urandom_range(0, 3)));
        end

        // Starvation: A and CPU both held; CPU must win every fourth window.
        bus.ADDR_A   = 19'h01234;
        bus.CPU_ADDR = 19'h41111;
        bus.CPU_AB   = 2'd1;
        exp_seq = {K_A, K_A, K_A, K_CPU, K_A, K_A, K_A, K_CPU};
        for (int i = 7; i >= 0; i--) begin
            k = (i == 4 || i == 0) ? K_CPU : K_A;
            exp_q.push_back(exp_entry(k, (k == K_CPU) ? 19'h41111 : 19'h01234, 2'd1));
        end
        got_seq = '0;
        n_gnt = 0;
        bus.REQ_A   = 1'b1;
        bus.CPU_REQ = 1'b1;
        for (int i = 0; i < 10 * SLOT_CYCLES && n_gnt < 8; i++) begin
            @(negedge M24);
            if (bus.SLOT0 && !bus.ROM_CEn) begin
                k = bus.GNT_A ? K_A : (bus.GNT_B ? K_B : K_CPU);
                got_seq = {got_seq[13:0], k};
                n_gnt++;
            end
        end
        #1;
        bus.REQ_A   = 1'b0;
        bus.CPU_REQ = 1'b0;
        check("starve_seq", {48'd0, got_seq}, {48'd0, exp_seq});
        wait_drain();

        // Reset in cycle 3 of an A window: access is dropped without VLD.
        bus.ADDR_A = 19'h00777;
        bus.REQ_A  = 1'b1;
        for (int i = 0; i < 3 * SLOT_CYCLES && !bus.GNT_A; i++) @(negedge M24);
        check("mid_gnt", {63'd0, bus.GNT_A}, 64'd1);
        #1;
        bus.REQ_A = 1'b0;
        repeat (3) @(negedge M24);
        RES = 1'b0;
        #1;
        check("mid_rst_ctl", {61'd0, bus.ROM_CEn, bus.ROM_OEn_LO, bus.BUSY}, 64'd6);
        repeat (2) @(negedge M24);
        RES = 1'b1;
        bad = 0;
        for (int i = 0; i < 2 * SLOT_CYCLES; i++) begin
            @(negedge M24);
            if (bus.ROM_CEn !== 1'b1 || bus.VLD_A !== 1'b0) bad++;
        end
        check("mid_after_idle", bad, 64'd0);

        // REQ_A held across reset: granted in the very first window.
        exp_q.push_back(exp_entry(K_A, 19'h40777, 2'd0));
        bus.ADDR_A = 19'h40777;
        bus.REQ_A  = 1'b1;
        RES = 1'b0;
        repeat (2) @(negedge M24);
        RES = 1'b1;
        @(negedge M24);
        check("first_window_gnt", {63'd0, bus.GNT_A}, 64'd1);
        #1;
        bus.REQ_A = 1'b0;
        wait_drain();
        repeat (SLOT_CYCLES) @(negedge M24);
        check("final_queue", exp_q.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gfx_rom_slot_arbiter.md
Name: gfx_rom_slot_arbiter

Overview:
- Time-slot arbiter and sequencer for the shared 512Kx32 tile GFX ROM bus (ROM_ADDR[18:0], split into lower/upper halves by bit 18) feeding the k051962 VC inputs.
- Grants one ROM access per fixed window to one of three requesters: tilemap fetch A, tilemap fetch B, or CPU ROM readback (RMRD path).
- Drives chip-enable and half-select output-enables, captures the 32-bit word, and returns it with a valid strobe.

Parameters:
- SLOT_CYCLES, 8: M24 cycles per access window (333.3 ns at 24 MHz).
- ROM_LAT, 5: window cycle on whose closing edge ROM_DATA is sampled; legal range 1..SLOT_CYCLES-2.
- STARVE_MAX, 3: consecutive lost windows after which a pending CPU request overrides A and B.

Ports:
- M24  in  1  master clock, 24 MHz
- RES  in  1  asynchronous active-low reset
- REQ_A  in  1  layer A fetch request, level; ADDR_A held while high
- ADDR_A  in  19  layer A ROM word address
- GNT_A  out  1  one-cycle grant pulse
- VLD_A  out  1  one-cycle pulse; RDATA holds A's word
- REQ_B, ADDR_B, GNT_B, VLD_B: same as A, for layer B
- CPU_REQ  in  1  CPU readback request, level
- CPU_ADDR  in  19  CPU ROM word address
- CPU_AB  in  2  byte select within the 32-bit word
- CPU_ACK  out  1  one-cycle pulse; CPU_DB valid
- CPU_DB  out  8  selected byte, held until next CPU_ACK
- ROM_ADDR  out  19  ROM word address
- ROM_CEn  out  1  ROM chip enable, active low
- ROM_OEn_LO  out  1  low when ROM_ADDR[18]=0 and access active
- ROM_OEn_HI  out  1  low when ROM_ADDR[18]=1 and access active
- ROM_DATA  in  32  ROM data bus
- RDATA  out  32  last captured word
- SLOT0  out  1  high during window cycle 0
- BUSY  out  1  high while an access is in flight

Behaviour:
- Reset (RES=0, asynchronous, any time):
  - slot_cnt=0, owner=NONE, starve=0.
  - ROM_ADDR=0; ROM_CEn, ROM_OEn_LO and ROM_OEn_HI =1.
  - All GNT, VLD and ACK =0; RDATA=0; CPU_DB=0; BUSY=0.
  - An in-flight access is discarded and issues no VLD/ACK.
  - First window starts on the first edge after RES rises.
- slot_cnt is free-running 0..SLOT_CYCLES-1 and wraps to 0. SLOT0 = (slot_cnt==0), registered.
- Arbitration: sampled on the edge that enters cycle 0.
  - Priority is A > B > CPU, except when starve==STARVE_MAX and CPU_REQ=1: CPU wins.
  - No request: idle window. ROM_CEn and both OEn stay 1, ROM_ADDR holds its previous value, BUSY=0.
- Winning window timeline:
  - Cycle 0: ROM_ADDR = winner's address, held for the whole window. ROM_CEn=0. OEn per bit 18. GNT_x=1 for this cycle only. BUSY=1.
  - On the edge closing cycle ROM_LAT: RDATA <= ROM_DATA. For a CPU access, CPU_DB <= ROM_DATA byte CPU_AB (0=[7:0] .. 3=[31:24]); CPU_AB is sampled at grant.
  - Cycle ROM_LAT+1: VLD_x or CPU_ACK =1 for one cycle. ROM_CEn, OEn and BUSY return to 1/1/0.
- Requester protocol:
  - A requester drops REQ in the cycle it sees GNT, or keeps it high to request the next window.
  - Dropping REQ before a grant cancels the request silently.
  - Dropping REQ after a grant does not abort; the data is still delivered.
- starve counter:
  - +1 (saturating at STARVE_MAX) per window where CPU_REQ=1 and another requester won.
  - Cleared on CPU grant or whenever CPU_REQ=0 at arbitration.
- Simultaneous events: arbitration and VLD of the previous window never coincide, because VLD falls in cycle ROM_LAT+1 ≤ SLOT_CYCLES-1.
- At most one grant per window. No back-to-back overlap on the ROM bus.

Test Plan:
- Reset and idle: RES low 3 cycles, no requests, 4 windows -> ROM_CEn, ROM_OEn_LO and ROM_OEn_HI all stay 1; SLOT0 pulses every 8 cycles; all strobes 0.
- Single A fetch: REQ_A=1, ADDR_A=19'h00003 -> GNT_A in cycle 0; ROM_ADDR=00003; ROM_OEn_LO=0, ROM_OEn_HI=1; ROM model word 32'hA5A5_0F0F -> RDATA matches and VLD_A is seen in cycle 6.
- Upper-half select: REQ_B, ADDR_B=19'h4001C -> ROM_OEn_HI=0, ROM_OEn_LO=1 for cycles 0..5; VLD_B in cycle 6.
- CPU byte select: CPU_REQ, CPU_ADDR=19'h00020, CPU_AB=2, ROM word 32'h1122_3344 -> CPU_ACK in cycle 6, CPU_DB=8'h22.
- Starvation override: REQ_A held continuously, CPU_REQ held -> A wins 3 windows; window 4 is granted to CPU; window 5 returns to A; starve is cleared.
- Reset mid-access: assert RES in cycle 3 of an A window -> ROM_CEn=1 immediately; no VLD_A; after release the first window is idle unless REQ_A is still high.
